// File: rtl/sprite_eval.sv
// Per-scanline sprite evaluator: scans primary OAM into an 8-entry secondary OAM,
// then presents each slot to the pattern fetcher during the fetch window.
module sprite_eval (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] cycle,
    input  logic [8:0] scanline,
    input  logic       render_en,
    input  logic       sp_size16,
    output logic [7:0] oam_addr,
    input  logic [7:0] oam_data,
    output logic       eval,
    output logic [7:0] tile_o,
    output logic [7:0] at_o,
    output logic [7:0] x_o,
    output logic [3:0] row_o,
    output logic       inscan_o,
    output logic       spr0_in_line,
    output logic       sp_overflow
);

    typedef enum logic [2:0] {IDLE, SCAN, COPY, OVF, DONE} state_t;

    state_t     state, state_next;
    logic [5:0] n, n_next;
    logic [1:0] m, m_next;
    logic [3:0] found, found_next;
    logic       spr0_next;
    logic [7:0] oam2 [32];

    logic       line_active, in_eval, step, in_range, clear_cyc;
    logic [8:0] d;
    logic [4:0] clr_idx;
    logic       wr_en, set_spr0, set_ovf;
    logic [4:0] wr_addr;

    assign line_active = render_en && (scanline <= 9'd239);
    assign in_eval     = line_active && (cycle >= 9'd65) && (cycle <= 9'd256);
    assign step        = in_eval && !cycle[0];
    assign d           = scanline - {1'b0, oam_data};
    assign in_range    = d < (sp_size16 ? 9'd16 : 9'd8);
    assign clear_cyc   = line_active && (cycle >= 9'd1) && (cycle <= 9'd64);
    // Byte (c-1)>>1 for c in 1..64, using only the low six bits of the dot.
    assign clr_idx     = cycle[0] ? cycle[5:1] : cycle[5:1] - 5'd1;
    assign oam_addr    = in_eval ? {n, m} : 8'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Even dots consume the byte addressed on the preceding odd dot.
    always_comb begin
        state_next = state;
        n_next     = n;
        m_next     = m;
        found_next = found;
        wr_en      = 1'b0;
        wr_addr    = {found[2:0], m};
        set_spr0   = 1'b0;
        set_ovf    = 1'b0;
        if (!line_active || cycle > 9'd256) begin
            state_next = IDLE;
        end else if (cycle == 9'd64) begin
            state_next = SCAN;
            n_next     = 6'd0;
            m_next     = 2'd0;
        end else if (step) begin
            case (state)
                SCAN: begin
                    if (in_range) begin
                        wr_en      = 1'b1;
                        m_next     = 2'd1;
                        state_next = COPY;
                        set_spr0   = (n == 6'd0);
                    end else begin
                        n_next = n + 6'd1;
                        if (n == 6'd63) state_next = DONE;
                    end
                end
                COPY: begin
                    wr_en = 1'b1;
                    if (m == 2'd3) begin
                        found_next = found + 4'd1;
                        n_next     = n + 6'd1;
                        m_next     = 2'd0;
                        if (n == 6'd63)          state_next = DONE;
                        else if (found == 4'd7)  state_next = OVF;
                        else                     state_next = SCAN;
                    end else begin
                        m_next = m + 2'd1;
                    end
                end
                OVF: begin
                    // Diagonal walk: m advances with n and never carries into it.
                    if (in_range) begin
                        set_ovf    = 1'b1;
                        state_next = DONE;
                    end else begin
                        n_next = n + 6'd1;
                        m_next = m + 2'd1;
                        if (n == 6'd63) state_next = DONE;
                    end
                end
                default: ;
            endcase
            if (cycle == 9'd256) state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n            <= 6'd0;
            m            <= 2'd0;
            found        <= 4'd0;
            spr0_next    <= 1'b0;
            spr0_in_line <= 1'b0;
            sp_overflow  <= 1'b0;
            for (int i = 0; i < 32; i++) oam2[i] <= 8'hFF;
        end else begin
            n <= n_next;
            m <= m_next;
            if (clear_cyc) oam2[clr_idx] <= 8'hFF;
            if (wr_en)     oam2[wr_addr] <= oam_data;
            if (line_active && cycle == 9'd1) begin
                found     <= 4'd0;
                spr0_next <= 1'b0;
            end else begin
                found <= found_next;
                if (set_spr0) spr0_next <= 1'b1;
            end
            if (cycle == 9'd257) spr0_in_line <= spr0_next & line_active;
            if (scanline == 9'd261 && cycle == 9'd1) sp_overflow <= 1'b0;
            else if (set_ovf)                        sp_overflow <= 1'b1;
        end
    end

    logic [2:0] slot;
    logic [7:0] slot_y, slot_at;
    logic       real_slot;

    assign slot      = cycle[5:3];
    assign slot_y    = oam2[{slot, 2'd0}];
    assign slot_at   = oam2[{slot, 2'd2}];
    assign eval      = render_en && (cycle >= 9'd257) && (cycle <= 9'd320)
                       && ((scanline <= 9'd239) || (scanline == 9'd261));
    assign real_slot = eval && line_active && ({1'b0, slot} < found);

    // Empty slots present a transparent tile so the fetcher needs no special case.
    always_comb begin
        tile_o   = 8'hFF;
        at_o     = 8'h00;
        x_o      = 8'hFF;
        row_o    = 4'd0;
        inscan_o = 1'b0;
        if (real_slot) begin
            inscan_o = 1'b1;
            tile_o   = oam2[{slot, 2'd1}];
            at_o     = slot_at;
            x_o      = oam2[{slot, 2'd3}];
            row_o    = (scanline[3:0] - slot_y[3:0])
                       ^ (slot_at[7] ? (sp_size16 ? 4'hF : 4'h7) : 4'h0);
        end
    end

endmodule

// File: tb/tb_sprite_eval.sv
// Directed bench for sprite_eval: table of single-line scenarios plus
// hand-written multi-line sequences (flag persistence, render drop, mid-line reset).
module tb_sprite_eval;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] cycle, scanline;
    logic       render_en, sp_size16;
    logic [7:0] oam_addr, oam_data;
    logic       eval, inscan_o, spr0_in_line, sp_overflow;
    logic [7:0] tile_o, at_o, x_o;
    logic [3:0] row_o;

    logic [7:0] oam_mem [256];
    int total = 0;
    int bad   = 0;

    logic [7:0] cap_tile [8];
    logic [7:0] cap_at [8];
    logic [7:0] cap_x [8];
    logic [3:0] cap_row [8];
    int   cap_cnt, cap_addr67, cap_ovf0, cap_ovf5, cap_ovf_late;
    int   cap_spr0_early, cap_spr0_late, cap_eval_all, cap_eval_any, cap_addr_late;

    typedef struct {
        int   setup;
        int   sl;
        logic s16;
        int   tile0, at0, x0, row0, cnt, x7, addr67, ovf, spr0;
    } vec_t;
    vec_t vecs [7];

    sprite_eval dut (
        .clk(clk), .rst(rst), .cycle(cycle), .scanline(scanline),
        .render_en(render_en), .sp_size16(sp_size16),
        .oam_addr(oam_addr), .oam_data(oam_data), .eval(eval),
        .tile_o(tile_o), .at_o(at_o), .x_o(x_o), .row_o(row_o),
        .inscan_o(inscan_o), .spr0_in_line(spr0_in_line), .sp_overflow(sp_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) oam_data <= oam_mem[oam_addr];

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic loadSetup(input int id);
        for (int i = 0; i < 256; i++) oam_mem[i] = 8'hF0;
        case (id)
            1, 2: begin
                oam_mem[20] = 8'd20; oam_mem[21] = 8'h42;
                oam_mem[22] = (id == 2) ? 8'h81 : 8'h01; oam_mem[23] = 8'd100;
            end
            3: begin
                oam_mem[0] = 8'd0; oam_mem[1] = 8'h11; oam_mem[2] = 8'h22; oam_mem[3] = 8'h33;
            end
            4, 5, 6: begin
                for (int i = 0; i < ((id == 4) ? 9 : 8); i++) begin
                    oam_mem[4*i]   = 8'd50;
                    oam_mem[4*i+1] = 8'(8'h10 + i);
                    oam_mem[4*i+2] = 8'h00;
                    oam_mem[4*i+3] = 8'(8 * i);
                end
                if (id == 5) oam_mem[37] = 8'd50;
                if (id == 6) oam_mem[36] = 8'd50;
            end
            default: ;
        endcase
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Runs one full line (dots 0-340); entered and left 1 time unit after a rising edge.
    task automatic applyStimulus(input int sl, input int drop_at, input int rst_at);
        render_en     = 1'b1;
        cap_cnt       = 0;
        cap_eval_all  = 1;
        cap_eval_any  = 0;
        cap_addr_late = 0;
        for (int c = 0; c <= 340; c++) begin
            rst      = 1'b0;
            cycle    = 9'(c);
            scanline = 9'(sl);
            if (c == drop_at) render_en = 1'b0;
            if (c == rst_at)  rst = 1'b1;
            #1;
            if (c == 0)   cap_ovf0 = int'(sp_overflow);
            if (c == 5)   cap_ovf5 = int'(sp_overflow);
            if (c == 67)  cap_addr67 = int'(oam_addr);
            if (c == 200) cap_spr0_early = int'(spr0_in_line);
            if (c == 300) begin
                cap_spr0_late = int'(spr0_in_line);
                cap_ovf_late  = int'(sp_overflow);
            end
            if (c > 100 && oam_addr != 8'd0) cap_addr_late = 1;
            if (c >= 257 && c <= 320) begin
                if (!eval) cap_eval_all = 0;
                if (eval)  cap_eval_any = 1;
                if (((c - 260) % 8) == 0 && c <= 316) begin
                    cap_tile[(c-260)/8] = tile_o;
                    cap_at[(c-260)/8]   = at_o;
                    cap_x[(c-260)/8]    = x_o;
                    cap_row[(c-260)/8]  = row_o;
                    if (inscan_o) cap_cnt++;
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0, 10, 1'b0, 8'hFF, 8'h00, 8'hFF, 0,  0, 255, 4, 0, 0};
        vecs[1] = '{1, 25, 1'b0, 8'h42, 8'h01, 100,   5,  1, 255, 4, 0, 0};
        vecs[2] = '{2, 25, 1'b1, 8'h42, 8'h81, 100,   10, 1, 255, 4, 0, 0};
        vecs[3] = '{3, 3,  1'b0, 8'h11, 8'h22, 8'h33, 3,  1, 255, 1, 0, 1};
        vecs[4] = '{4, 52, 1'b0, 8'h10, 8'h00, 0,     2,  8, 56,  1, 1, 1};
        vecs[5] = '{5, 52, 1'b0, 8'h10, 8'h00, 0,     2,  8, 56,  1, 1, 1};
        vecs[6] = '{6, 52, 1'b0, 8'h10, 8'h00, 0,     2,  8, 56,  1, 0, 1};

        rst = 1'b1; cycle = 9'd0; scanline = 9'd0; render_en = 1'b1; sp_size16 = 1'b0;
        loadSetup(0);
        @(posedge clk); @(posedge clk); #1;
        checkOutput("rst oam_addr", int'(oam_addr), 0);
        checkOutput("rst eval", int'(eval), 0);
        checkOutput("rst inscan", int'(inscan_o), 0);
        checkOutput("rst tile", int'(tile_o), 255);
        checkOutput("rst at", int'(at_o), 0);
        checkOutput("rst x", int'(x_o), 255);
        checkOutput("rst row", int'(row_o), 0);
        checkOutput("rst spr0", int'(spr0_in_line), 0);
        checkOutput("rst ovf", int'(sp_overflow), 0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            pulseReset();
            loadSetup(vecs[k].setup);
            sp_size16 = vecs[k].s16;
            applyStimulus(vecs[k].sl, -1, -1);
            checkOutput($sformatf("v%0d tile0", k), int'(cap_tile[0]), vecs[k].tile0);
            checkOutput($sformatf("v%0d at0", k), int'(cap_at[0]), vecs[k].at0);
            checkOutput($sformatf("v%0d x0", k), int'(cap_x[0]), vecs[k].x0);
            checkOutput($sformatf("v%0d row0", k), int'(cap_row[0]), vecs[k].row0);
            checkOutput($sformatf("v%0d inscan count", k), cap_cnt, vecs[k].cnt);
            checkOutput($sformatf("v%0d x7", k), int'(cap_x[7]), vecs[k].x7);
            checkOutput($sformatf("v%0d addr@67", k), cap_addr67, vecs[k].addr67);
            checkOutput($sformatf("v%0d ovf", k), cap_ovf_late, vecs[k].ovf);
            checkOutput($sformatf("v%0d spr0", k), cap_spr0_late, vecs[k].spr0);
            checkOutput($sformatf("v%0d eval window", k), cap_eval_all, 1);
        end
        sp_size16 = 1'b0;

        // spr0_in_line holds across the next line until that line's dot 257.
        pulseReset();
        loadSetup(3);
        applyStimulus(3, -1, -1);
        loadSetup(0);
        applyStimulus(4, -1, -1);
        checkOutput("spr0 held next line", cap_spr0_early, 1);
        checkOutput("spr0 dropped after 257", cap_spr0_late, 0);

        // Overflow is sticky through 239 and clears at line 261 dot 1.
        pulseReset();
        loadSetup(4);
        applyStimulus(52, -1, -1);
        applyStimulus(239, -1, -1);
        checkOutput("ovf sticky 239", cap_ovf_late, 1);
        applyStimulus(261, -1, -1);
        checkOutput("ovf before clear", cap_ovf0, 1);
        checkOutput("ovf cleared 261", cap_ovf5, 0);
        checkOutput("eval on 261", cap_eval_all, 1);
        checkOutput("slots empty 261", cap_cnt, 0);

        // Rendering disabled mid-evaluation.
        pulseReset();
        loadSetup(5);
        applyStimulus(52, 100, -1);
        checkOutput("drop oam_addr", cap_addr_late, 0);
        checkOutput("drop eval", cap_eval_any, 0);
        checkOutput("drop ovf", cap_ovf_late, 0);

        // Reset mid-line empties the line; the next line evaluates normally.
        pulseReset();
        loadSetup(1);
        applyStimulus(25, -1, 150);
        checkOutput("midrst count", cap_cnt, 0);
        checkOutput("midrst tile0", int'(cap_tile[0]), 255);
        applyStimulus(25, -1, -1);
        checkOutput("after midrst count", cap_cnt, 1);
        checkOutput("after midrst tile0", int'(cap_tile[0]), 8'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
